// File: rtl/alu.sv
// Purpose: 16-bit ALU (add/sub with signed overflow, and/or/not, negate,
//          1-bit shifts) plus registered result/flag and sticky overflow.
// Latency: C/OverflowFlag are combinational (0 cycles); C_q, OverflowFlag_q
//          and OverflowSticky update on the next rising clk. No backpressure.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   A, B                 operands (B used by ADD/SUB/AND/ORR only)
//   FuncCode             000 ADD, 001 SUB, 010 AND, 011 ORR,
//                        100 NOT, 101 TCP, 110 SHL, 111 SHR
//   C, OverflowFlag      combinational result and signed overflow
//   C_q, OverflowFlag_q  registered copies of C and OverflowFlag
//   OverflowSticky       set on any clk edge where OverflowFlag=1
module alu #(
  parameter int NumBits = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NumBits-1:0] A,
  input  logic [NumBits-1:0] B,
  input  logic [2:0]         FuncCode,
  output logic [NumBits-1:0] C,
  output logic               OverflowFlag,
  output logic [NumBits-1:0] C_q,
  output logic               OverflowFlag_q,
  output logic               OverflowSticky
);

  localparam int Msb = NumBits - 1;

  // Unsigned carry/borrow out of the top bit is intentionally dropped.
  logic [NumBits-1:0] sum_dat;
  logic [NumBits-1:0] diff_dat;
  logic               sticky_d;

  assign sum_dat  = A + B;
  assign diff_dat = A - B;

  always_comb begin
    // Zero default also covers an unknown FuncCode in simulation.
    C            = '0;
    OverflowFlag = 1'b0;
    case (FuncCode)
      3'b000: begin
        C            = sum_dat;
        // Operands share a sign but the result does not.
        OverflowFlag = (A[Msb] == B[Msb]) && (sum_dat[Msb] != A[Msb]);
      end
      3'b001: begin
        C            = diff_dat;
        // Operands differ in sign and the result took the subtrahend's sign.
        OverflowFlag = (A[Msb] != B[Msb]) && (diff_dat[Msb] != A[Msb]);
      end
      3'b010:  C = A & B;
      3'b011:  C = A | B;
      3'b100:  C = ~A;
      // Negating the most negative value wraps to itself; no flag raised.
      3'b101:  C = -A;
      3'b110:  C = {A[Msb-1:0], 1'b0};
      3'b111:  C = {A[Msb], A[Msb:1]};
      default: begin
        C            = '0;
        OverflowFlag = 1'b0;
      end
    endcase
  end

  assign sticky_d = OverflowSticky | OverflowFlag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      C_q            <= '0;
      OverflowFlag_q <= 1'b0;
      OverflowSticky <= 1'b0;
    end else begin
      C_q            <= C;
      OverflowFlag_q <= OverflowFlag;
      OverflowSticky <= sticky_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Purpose: self-checking bench for alu: directed vectors, register/reset
//          behaviour, and randomized operations against an arithmetic model.
// Latency: combinational outputs sampled #1 after input change; registered
//          outputs sampled #1 after the rising edge. No backpressure.
module tb_alu;

  logic        clk;
  logic        reset_n;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  FuncCode;
  logic [15:0] C;
  logic        OverflowFlag;
  logic [15:0] C_q;
  logic        OverflowFlag_q;
  logic        OverflowSticky;

  int n_checks;
  int n_pass;

  alu #(.NumBits(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .A              (A),
    .B              (B),
    .FuncCode       (FuncCode),
    .C              (C),
    .OverflowFlag   (OverflowFlag),
    .C_q            (C_q),
    .OverflowFlag_q (OverflowFlag_q),
    .OverflowSticky (OverflowSticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: operands treated as signed integers, result wrapped to
  // 16 bits; overflow means the true signed result does not fit in 16 bits.
  function automatic void ref_alu(input logic [15:0] a, input logic [15:0] b,
                                  input logic [2:0] f,
                                  output logic [15:0] c, output logic of);
    int sa;
    int sb;
    int r;
    sa = $signed(a);
    sb = $signed(b);
    of = 1'b0;
    case (f)
      3'd0: begin r = sa + sb; of = (r > 32767) || (r < -32768); end
      3'd1: begin r = sa - sb; of = (r > 32767) || (r < -32768); end
      3'd2: r = int'(a) & int'(b);
      3'd3: r = int'(a) | int'(b);
      3'd4: r = 65535 - int'(a);
      3'd5: r = -sa;
      3'd6: r = sa * 2;
      default: r = (sa >= 0) ? sa / 2 : (sa - 1) / 2;  // floor(sa/2)
    endcase
    c = r[15:0];
  endfunction

  task automatic apply(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
    FuncCode = f;
    A        = a;
    B        = b;
    #1;
  endtask

  task automatic vec(input string tag, input logic [2:0] f, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] ec, input logic eof);
    apply(f, a, b);
    check({tag, ".C"}, 32'(C), 32'(ec));
    check({tag, ".OF"}, 32'(OverflowFlag), 32'(eof));
  endtask

  task automatic check_regs(input string tag, input logic [15:0] ec,
                            input logic eof, input logic est);
    check({tag, ".C_q"}, 32'(C_q), 32'(ec));
    check({tag, ".OF_q"}, 32'(OverflowFlag_q), 32'(eof));
    check({tag, ".sticky"}, 32'(OverflowSticky), 32'(est));
  endtask

  initial begin
    logic [15:0] mc;
    logic        mof;
    logic [15:0] m_cq;
    logic        m_ofq;
    logic        m_sticky;

    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    A        = 16'h0;
    B        = 16'h0;
    FuncCode = 3'd0;
    #1;
    check_regs("reset", 16'h0, 1'b0, 1'b0);

    // Directed vectors (combinational, reset still asserted: must not matter)
    vec("add0", 3'd0, 16'h7fff, 16'h0005, 16'h8004, 1'b1);
    vec("add1", 3'd0, 16'h8000, 16'h8001, 16'h0001, 1'b1);
    vec("add2", 3'd0, 16'hffff, 16'h0001, 16'h0000, 1'b0);
    vec("add3", 3'd0, 16'h0fff, 16'h0001, 16'h1000, 1'b0);
    vec("sub0", 3'd1, 16'h7fff, 16'hffff, 16'h8000, 1'b1);
    vec("sub1", 3'd1, 16'hffff, 16'h8001, 16'h7ffe, 1'b0);
    vec("sub2", 3'd1, 16'h0002, 16'h0003, 16'hffff, 1'b0);
    vec("sub3", 3'd1, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    vec("and0", 3'd2, 16'hffff, 16'h0001, 16'h0001, 1'b0);
    vec("orr0", 3'd3, 16'hffff, 16'h0001, 16'hffff, 1'b0);
    vec("not0", 3'd4, 16'h0800, 16'h1234, 16'hf7ff, 1'b0);
    vec("tcp0", 3'd5, 16'hffff, 16'h0000, 16'h0001, 1'b0);
    vec("tcp1", 3'd5, 16'h0800, 16'h0000, 16'hf800, 1'b0);
    vec("tcp2", 3'd5, 16'hf0f1, 16'h0000, 16'h0f0f, 1'b0);
    vec("tcp3", 3'd5, 16'h8000, 16'h0000, 16'h8000, 1'b0);
    vec("shl0", 3'd6, 16'h0800, 16'h0000, 16'h1000, 1'b0);
    vec("shl1", 3'd6, 16'h8000, 16'h0000, 16'h0000, 1'b0);
    vec("shr0", 3'd7, 16'h0800, 16'h0000, 16'h0400, 1'b0);
    vec("shr1", 3'd7, 16'h8000, 16'h0000, 16'hc000, 1'b0);
    vec("shr2", 3'd7, 16'hf001, 16'h0000, 16'hf800, 1'b0);

    // Registers held in reset across a clock edge
    @(posedge clk); #1;
    check_regs("rst_hold", 16'h0, 1'b0, 1'b0);

    // Release, then ADD overflow captured on the first edge
    @(negedge clk);
    reset_n = 1'b1;
    apply(3'd0, 16'h7fff, 16'h0001);
    @(posedge clk); #1;
    check_regs("reg_add", 16'h8000, 1'b1, 1'b1);

    @(negedge clk);
    apply(3'd2, 16'hffff, 16'h00f0);
    @(posedge clk); #1;
    check_regs("reg_and", 16'h00f0, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle clears immediately, no clock needed
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_regs("async_rst", 16'h0, 1'b0, 1'b0);
    check("async_rst.C", 32'(C), 32'h00f0);
    @(posedge clk); #1;
    check_regs("async_hold", 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized operations with model-tracked registers
    m_cq     = 16'h0;
    m_ofq    = 1'b0;
    m_sticky = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic [2:0]  rf;
      @(negedge clk);
      ra = 16'($urandom);
      rb = 16'($urandom);
      rf = 3'($urandom_range(0, 7));
      // Occasionally bias toward sign-boundary operands
      if ($urandom_range(0, 3) == 0) ra = {ra[15], {15{~ra[15]}}};
      apply(rf, ra, rb);
      ref_alu(ra, rb, rf, mc, mof);
      check($sformatf("rnd%0d.C f%0d %h %h", i, rf, ra, rb), 32'(C), 32'(mc));
      check($sformatf("rnd%0d.OF f%0d %h %h", i, rf, ra, rb), 32'(OverflowFlag), 32'(mof));
      @(posedge clk); #1;
      m_cq     = mc;
      m_ofq    = mof;
      m_sticky = m_sticky | mof;
      if (i % 10 == 9) check_regs($sformatf("rnd%0d", i), m_cq, m_ofq, m_sticky);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
